// File: rtl/nou_fetch_pkg.sv
// Shared NOU widths, fetch queue depth and the entry packing used by fetch and decode.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: width macros (SID, XOCC command, unit vector, fetch depth, entry width) and matching localparams.

`ifndef NOU_DEFINE_H
`define NOU_DEFINE_H
`define NOU_SID_WIDTH      4
`define NOU_XOCC_CMD_WIDTH 8
`define NOU_UOV_SIZE       4
`define NOU_FETCH_DEPTH    8
// Entry seen by decode: {unit_mask, cmd, sid, valid}, valid in bit 0.
`define NOU_ENTRY_WIDTH    (1 + `NOU_SID_WIDTH + `NOU_XOCC_CMD_WIDTH + `NOU_UOV_SIZE)
`endif

package nou_fetch_pkg;

  localparam int NOU_SID_W   = `NOU_SID_WIDTH;
  localparam int NOU_CMD_W   = `NOU_XOCC_CMD_WIDTH;
  localparam int NOU_UOV_W   = `NOU_UOV_SIZE;
  localparam int NOU_DEPTH   = `NOU_FETCH_DEPTH;
  localparam int NOU_ENTRY_W = `NOU_ENTRY_WIDTH;

  // Queue record at the default widths (entry minus the valid bit).
  typedef struct packed {
    logic [NOU_UOV_W-1:0] unit_mask;
    logic [NOU_CMD_W-1:0] cmd;
    logic [NOU_SID_W-1:0] sid;
  } fetch_rec_t;

endpackage

// File: rtl/nou_fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags.
// Latency: a push is readable at head_dat from the following cycle; no write-through bypass.
// Backpressure: pushes while full and pops while empty are dropped; flush wins over push/pop.
// Ports: clk, rstn (async active-low), push/push_dat, pop, flush, head_dat, full, empty, count.

module nou_fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Index bits plus one wrap bit each.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      // Equalising the pointers empties the queue; the write side keeps its place.
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only observed through head_dat while not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  // Wrap-bit pointers make the plain difference range over 0..DEPTH.
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/nou_fetch.sv
// Fetch stage: tags host XOCC commands with a wrapping SID and queues them in order for decode.
// Latency: accepted in cycle N, visible on entry_input in N+1 at the earliest (no bypass).
// Backpressure: host_cmd_rdy = !full (and low in reset / flush cycles); decode pops with decode_issue_ack.
// Ports: clk, rstn, host_cmd_vld/host_cmd_rdy/host_cmd/host_unit_mask, fetch_flush,
//        entry_input/entry_input_valid/decode_issue_ack, fetch_count, fetch_sid_next.

module nou_fetch
  import nou_fetch_pkg::*;
#(
  parameter int DEPTH = NOU_DEPTH,
  parameter int SID_W = NOU_SID_W,
  parameter int CMD_W = NOU_CMD_W,
  parameter int UOV_W = NOU_UOV_W
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           host_cmd_vld,
  output logic                           host_cmd_rdy,
  input  logic [CMD_W-1:0]               host_cmd,
  input  logic [UOV_W-1:0]               host_unit_mask,
  input  logic                           fetch_flush,
  output logic [UOV_W+CMD_W+SID_W:0]     entry_input,
  output logic                           entry_input_valid,
  input  logic                           decode_issue_ack,
  output logic [$clog2(DEPTH):0]         fetch_count,
  output logic [SID_W-1:0]               fetch_sid_next
);

  localparam int REC_W = UOV_W + CMD_W + SID_W;

  logic              live_q;
  logic [SID_W-1:0]  sid_ctr;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [REC_W-1:0]  head_rec;

  // live_q keeps the host port closed while reset is held and opens it one edge after release.
  // No term from decode_issue_ack: a pop never frees a slot for a same-cycle push.
  assign host_cmd_rdy      = live_q & ~full & ~fetch_flush;
  assign push              = host_cmd_vld & host_cmd_rdy;
  assign entry_input_valid = ~empty;
  assign pop               = decode_issue_ack & entry_input_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q  <= 1'b0;
      sid_ctr <= '0;
    end else begin
      live_q <= 1'b1;
      // Flush does not rewind the counter, so SIDs stay monotonic across flushes.
      if (push) sid_ctr <= sid_ctr + SID_W'(1);
    end
  end

  nou_fetch_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_dat ({host_unit_mask, host_cmd, sid_ctr}),
    .pop      (pop),
    .flush    (fetch_flush),
    .head_dat (head_rec),
    .full     (full),
    .empty    (empty),
    .count    (fetch_count)
  );

  // Zero the whole entry when nothing is queued so decode never sees stale payload.
  assign entry_input    = entry_input_valid ? {head_rec, 1'b1} : '0;
  assign fetch_sid_next = sid_ctr;

endmodule

// File: tb/tb_nou_fetch.sv
// Self-checking bench for nou_fetch against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
// Ports: none (top-level bench).

module tb_nou_fetch;
  import nou_fetch_pkg::*;

  localparam int DEPTH = NOU_DEPTH;
  localparam int SID_W = NOU_SID_W;
  localparam int CMD_W = NOU_CMD_W;
  localparam int UOV_W = NOU_UOV_W;
  localparam int EW    = 1 + SID_W + CMD_W + UOV_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              host_cmd_vld;
  logic              host_cmd_rdy;
  logic [CMD_W-1:0]  host_cmd;
  logic [UOV_W-1:0]  host_unit_mask;
  logic              fetch_flush;
  logic [EW-1:0]     entry_input;
  logic              entry_input_valid;
  logic              decode_issue_ack;
  logic [CW-1:0]     fetch_count;
  logic [SID_W-1:0]  fetch_sid_next;

  nou_fetch #(.DEPTH(DEPTH), .SID_W(SID_W), .CMD_W(CMD_W), .UOV_W(UOV_W)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .host_cmd_vld      (host_cmd_vld),
    .host_cmd_rdy      (host_cmd_rdy),
    .host_cmd          (host_cmd),
    .host_unit_mask    (host_unit_mask),
    .fetch_flush       (fetch_flush),
    .entry_input       (entry_input),
    .entry_input_valid (entry_input_valid),
    .decode_issue_ack  (decode_issue_ack),
    .fetch_count       (fetch_count),
    .fetch_sid_next    (fetch_sid_next)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of expected entry_input words (valid bit included), next SID, port-open flag.
  logic [EW-1:0] mq[$];
  int unsigned   m_sid;
  bit            m_live;

  function automatic logic [EW-1:0] exp_entry();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  function automatic logic exp_rdy();
    return m_live && (mq.size() < DEPTH) && !fetch_flush;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, return #1 after the edge.
  task automatic step(input logic vld, input logic [CMD_W-1:0] cmd, input logic [UOV_W-1:0] mask,
                      input logic ack, input logic flush);
    bit            acc;
    bit            pp;
    logic [EW-1:0] tmp;
    host_cmd_vld     = vld;
    host_cmd         = cmd;
    host_unit_mask   = mask;
    decode_issue_ack = ack;
    fetch_flush      = flush;
    acc = m_live && vld && !flush && (mq.size() < DEPTH);
    pp  = ack && (mq.size() > 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pp) tmp = mq.pop_front();
      if (acc) mq.push_back({mask, cmd, SID_W'(m_sid), 1'b1});
    end
    if (acc) m_sid = (m_sid + 1) % (1 << SID_W);
    m_live = rstn;
    #1;
  endtask

  task automatic idle_inputs();
    host_cmd_vld = 0; host_cmd = '0; host_unit_mask = '0; decode_issue_ack = 0; fetch_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    mq.delete(); m_sid = 0; m_live = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    step(0, '0, '0, 0, 0);
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    host_cmd_vld = 1; host_cmd = 8'hA5; host_unit_mask = 4'hF;
    mq.delete(); m_sid = 0; m_live = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (host_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", host_cmd_rdy); end
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", entry_input_valid); end
    n_checks++; if (entry_input !== '0) begin n_fail++; $display("FAIL reset_entry: got %h want 0", entry_input); end
    n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    n_checks++; if (fetch_sid_next !== '0) begin n_fail++; $display("FAIL reset_sid: got %0d want 0", fetch_sid_next); end
    host_cmd_vld = 0;
    rstn = 1;
    step(0, '0, '0, 0, 0);
    n_checks++; if (host_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy: got %b want 1", host_cmd_rdy); end
    n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL reset_release_count: got %0d want 0", fetch_count); end
  endtask

  task automatic test_single();
    host_cmd_vld = 1; host_cmd = 8'h5A; host_unit_mask = 4'h3;
    #2;
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", entry_input_valid); end
    step(1, 8'h5A, 4'h3, 0, 0);
    n_checks++; if (entry_input_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", entry_input_valid); end
    n_checks++; if (entry_input[0] !== 1'b1) begin n_fail++; $display("FAIL single_bit0: got %b want 1", entry_input[0]); end
    n_checks++; if (entry_input[SID_W:1] !== 4'd0) begin n_fail++; $display("FAIL single_sid: got %0d want 0", entry_input[SID_W:1]); end
    n_checks++; if (entry_input[SID_W+CMD_W:SID_W+1] !== 8'h5A) begin n_fail++; $display("FAIL single_cmd: got %h want 5a", entry_input[SID_W+CMD_W:SID_W+1]); end
    n_checks++; if (entry_input[EW-1:SID_W+CMD_W+1] !== 4'h3) begin n_fail++; $display("FAIL single_mask: got %h want 3", entry_input[EW-1:SID_W+CMD_W+1]); end
    n_checks++; if (entry_input !== exp_entry()) begin n_fail++; $display("FAIL single_entry: got %h want %h", entry_input, exp_entry()); end
    step(0, '0, '0, 1, 0);
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", entry_input_valid); end
    n_checks++; if (fetch_sid_next !== 4'd1) begin n_fail++; $display("FAIL single_sid_next: got %0d want 1", fetch_sid_next); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1, CMD_W'($urandom), UOV_W'($urandom), 0, 0);
    n_checks++; if (fetch_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", fetch_count, DEPTH); end
    n_checks++; if (host_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_rdy: got %b want 0", host_cmd_rdy); end
    step(1, 8'hEE, 4'h1, 0, 0);
    n_checks++; if (fetch_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_ninth_count: got %0d want %0d", fetch_count, DEPTH); end
    n_checks++; if (fetch_sid_next !== SID_W'(m_sid)) begin n_fail++; $display("FAIL fill_ninth_sid: got %0d want %0d", fetch_sid_next, m_sid); end
    step(1, 8'hEF, 4'h2, 1, 0);
    n_checks++; if (fetch_count !== CW'(DEPTH-1)) begin n_fail++; $display("FAIL fill_ackpush_count: got %0d want %0d", fetch_count, DEPTH-1); end
    n_checks++; if (fetch_sid_next !== SID_W'(m_sid)) begin n_fail++; $display("FAIL fill_ackpush_sid: got %0d want %0d", fetch_sid_next, m_sid); end
    while (mq.size() > 0) begin
      n_checks++; if (entry_input !== exp_entry()) begin n_fail++; $display("FAIL fill_drain_entry: got %h want %h", entry_input, exp_entry()); end
      step(0, '0, '0, 1, 0);
    end
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained_valid: got %b want 0", entry_input_valid); end
  endtask

  task automatic test_sid_wrap();
    // Entries queued, then reset asserted mid-cycle: queue must clear without a clock edge.
    step(1, 8'h11, 4'h1, 0, 0);
    step(1, 8'h22, 4'h2, 0, 0);
    #2 rstn = 0;
    #1;
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", entry_input_valid); end
    n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", fetch_count); end
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(1, CMD_W'($urandom), UOV_W'($urandom), 0, 0);
      n_checks++; if (entry_input !== exp_entry()) begin n_fail++; $display("FAIL wrap_entry_%0d: got %h want %h", k, entry_input, exp_entry()); end
      if (k == 17) begin
        n_checks++; if (entry_input[SID_W:1] !== 4'd0) begin n_fail++; $display("FAIL wrap_sid17: got %0d want 0", entry_input[SID_W:1]); end
      end
      step(0, '0, '0, 1, 0);
    end
    n_checks++; if (fetch_sid_next !== 4'd1) begin n_fail++; $display("FAIL wrap_sid_next: got %0d want 1", fetch_sid_next); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, CMD_W'($urandom), UOV_W'($urandom), 0, 0);
    n_checks++; if (fetch_count !== CW'(3)) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", fetch_count); end
    fetch_flush = 1; host_cmd_vld = 1;
    #1;
    n_checks++; if (host_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_rdy: got %b want 0", host_cmd_rdy); end
    step(1, 8'h77, 4'h1, 1, 1);
    n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", fetch_count); end
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", entry_input_valid); end
    n_checks++; if (fetch_sid_next !== 4'd3) begin n_fail++; $display("FAIL flush_sid_next: got %0d want 3", fetch_sid_next); end
    step(1, 8'h12, 4'h4, 0, 0);
    n_checks++; if (entry_input[SID_W:1] !== 4'd3) begin n_fail++; $display("FAIL flush_next_sid: got %0d want 3", entry_input[SID_W:1]); end
    n_checks++; if (entry_input !== exp_entry()) begin n_fail++; $display("FAIL flush_next_entry: got %h want %h", entry_input, exp_entry()); end
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_stall();
    logic [EW-1:0] snap;
    for (int i = 0; i < 3; i++) step(1, CMD_W'($urandom), UOV_W'($urandom), 0, 0);
    snap = entry_input;
    for (int c = 0; c < 10; c++) begin
      step(0, '0, '0, 0, 0);
      n_checks++; if (entry_input !== snap || entry_input !== exp_entry()) begin n_fail++; $display("FAIL stall_hold_%0d: got %h want %h", c, entry_input, exp_entry()); end
    end
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL stall_idle_ack_count: got %0d want 0", fetch_count); end
    n_checks++; if (entry_input_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle_ack_valid: got %b want 0", entry_input_valid); end
  endtask

  task automatic test_random();
    int ack_pct;
    for (int i = 0; i < 600; i++) begin
      ack_pct = ((i / 100) % 2 == 0) ? 25 : 75;
      step(($urandom % 3) != 0, CMD_W'($urandom), UOV_W'($urandom),
           ($urandom % 100) < ack_pct, ($urandom % 40) == 0);
      n_checks++; if (entry_input !== exp_entry()) begin n_fail++; $display("FAIL rand_entry_%0d: got %h want %h", i, entry_input, exp_entry()); end
      n_checks++; if (fetch_count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count_%0d: got %0d want %0d", i, fetch_count, mq.size()); end
      n_checks++; if (fetch_sid_next !== SID_W'(m_sid)) begin n_fail++; $display("FAIL rand_sid_%0d: got %0d want %0d", i, fetch_sid_next, m_sid); end
      n_checks++; if (host_cmd_rdy !== exp_rdy()) begin n_fail++; $display("FAIL rand_rdy_%0d: got %b want %b", i, host_cmd_rdy, exp_rdy()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_sid_wrap();
    test_flush();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
